// File: rtl/calc_pkg.sv
// Shared constants for the calculator counter blocks: counter boundary modes
// and the BCD digit range.
package calc_pkg;
  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;
  localparam int BCD_MAX  = 9;
endpackage

// File: rtl/ud_cnt_chain.sv
// Multi-digit counter: NDIGITS ud_cnt_mod stages rippling carry combinationally,
// least significant digit in the low bits of the Q and D buses.
module ud_cnt_chain
  import calc_pkg::*;
#(
  parameter int NDIGITS  = 2,
  parameter int WIDTH    = 4,
  parameter int MOD_MAX  = BCD_MAX,
  parameter int SATURATE = CNT_WRAP
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CE,
  input  logic                     CLR,
  input  logic                     LD,
  input  logic [NDIGITS*WIDTH-1:0] D,
  input  logic                     UD,
  output logic [NDIGITS*WIDTH-1:0] Q,
  output logic                     CO,
  output logic                     OVF,
  output logic [NDIGITS-1:0]       OVF_DIG
);

  logic [NDIGITS:0] w_ci;

  assign w_ci[0] = 1'b1;

  for (genvar g = 0; g < NDIGITS; g++) begin : g_dig
    ud_cnt_mod #(
      .WIDTH   (WIDTH),
      .MOD_MAX (MOD_MAX),
      .SATURATE(SATURATE)
    ) u_dig (
      .CLK(CLK),
      .RST(RST),
      .CE (CE),
      .CLR(CLR),
      .LD (LD),
      .D  (D[g*WIDTH +: WIDTH]),
      .UD (UD),
      .CI (w_ci[g]),
      .Q  (Q[g*WIDTH +: WIDTH]),
      .CO (w_ci[g+1]),
      .OVF(OVF_DIG[g])
    );
  end

  assign CO  = w_ci[NDIGITS];
  assign OVF = OVF_DIG[NDIGITS-1];

endmodule

// File: rtl/ud_cnt_mod.sv
// Up/down modulo counter with parallel load, synchronous clear, wrap or
// saturate at the boundaries, and combinational carry for cascading.
module ud_cnt_mod
  import calc_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MOD_MAX  = BCD_MAX,
  parameter int SATURATE = CNT_WRAP
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             CLR,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic             UD,
  input  logic             CI,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             OVF
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD_MAX);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_ovf_nxt;
  logic             w_at_max;
  logic             w_at_min;

  assign w_at_max = (r_q == MAXV);
  assign w_at_min = (r_q == '0);

  // The boundary compare drives both the wrap and the carry, so a full-range
  // counter (MOD_MAX = 2^WIDTH-1) wraps explicitly rather than by overflow.
  always_comb begin
    w_q_nxt   = r_q;
    w_ovf_nxt = 1'b0;
    if (CLR) begin
      w_q_nxt = '0;
    end else if (CE && LD) begin
      w_q_nxt = (D > MAXV) ? MAXV : D;
    end else if (CE && CI) begin
      if (UD) begin
        if (!w_at_max) begin
          w_q_nxt = r_q + ONE;
        end else begin
          w_ovf_nxt = 1'b1;
          if (SATURATE == CNT_WRAP) w_q_nxt = '0;
        end
      end else begin
        if (!w_at_min) begin
          w_q_nxt = r_q - ONE;
        end else begin
          w_ovf_nxt = 1'b1;
          if (SATURATE == CNT_WRAP) w_q_nxt = MAXV;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_q   <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_q   <= w_q_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  assign Q   = r_q;
  assign OVF = r_ovf;
  assign CO  = CE & CI & ~LD & ~CLR & ((UD & w_at_max) | (~UD & w_at_min));

endmodule

// File: tb/tb_ud_cnt_mod.sv
// Directed bench for ud_cnt_mod (wrap and saturate builds) and a two-digit
// BCD ud_cnt_chain, with hand-computed expected values.
module tb_ud_cnt_mod;
  import calc_pkg::*;

  typedef struct {
    logic       ce, clr, ld, ud, ci;
    logic [3:0] d;
    logic       exp_co;
    logic [3:0] exp_q;
    logic       exp_ovf;
  } vec_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  // wrap instance
  logic w_ce = 0, w_clr = 0, w_ld = 0, w_ud = 0, w_ci = 0;
  logic [3:0] w_d = '0, w_q;
  logic w_co, w_ovf;
  // saturate instance
  logic s_ce = 0, s_clr = 0, s_ld = 0, s_ud = 0, s_ci = 0;
  logic [3:0] s_d = '0, s_q;
  logic s_co, s_ovf;
  // two-digit chain
  logic c_ce = 0, c_clr = 0, c_ld = 0, c_ud = 0;
  logic [7:0] c_d = '0, c_q;
  logic c_co, c_ovf;
  logic [1:0] c_ovf_dig;

  int checks = 0;
  int failures = 0;

  ud_cnt_mod #(.WIDTH(4), .MOD_MAX(BCD_MAX), .SATURATE(CNT_WRAP)) u_wrap (
    .CLK(CLK), .RST(RST), .CE(w_ce), .CLR(w_clr), .LD(w_ld), .D(w_d),
    .UD(w_ud), .CI(w_ci), .Q(w_q), .CO(w_co), .OVF(w_ovf));

  ud_cnt_mod #(.WIDTH(4), .MOD_MAX(BCD_MAX), .SATURATE(CNT_SAT)) u_sat (
    .CLK(CLK), .RST(RST), .CE(s_ce), .CLR(s_clr), .LD(s_ld), .D(s_d),
    .UD(s_ud), .CI(s_ci), .Q(s_q), .CO(s_co), .OVF(s_ovf));

  ud_cnt_chain #(.NDIGITS(2), .WIDTH(4), .MOD_MAX(BCD_MAX), .SATURATE(CNT_WRAP)) u_chain (
    .CLK(CLK), .RST(RST), .CE(c_ce), .CLR(c_clr), .LD(c_ld), .D(c_d),
    .UD(c_ud), .Q(c_q), .CO(c_co), .OVF(c_ovf), .OVF_DIG(c_ovf_dig));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic ce, clr, ld, ud, ci, input logic [3:0] d,
                              input logic co, input logic [3:0] q, input logic ovf);
    vec_t v;
    v.ce = ce; v.clr = clr; v.ld = ld; v.ud = ud; v.ci = ci; v.d = d;
    v.exp_co = co; v.exp_q = q; v.exp_ovf = ovf;
    return v;
  endfunction

  // sel 0 = wrap instance, 1 = saturate instance
  task automatic run_vec(input int sel, input vec_t v, input int idx);
    string tag;
    tag = (sel == 0) ? "wrap" : "sat";
    if (sel == 0) begin
      w_ce = v.ce; w_clr = v.clr; w_ld = v.ld; w_ud = v.ud; w_ci = v.ci; w_d = v.d;
    end else begin
      s_ce = v.ce; s_clr = v.clr; s_ld = v.ld; s_ud = v.ud; s_ci = v.ci; s_d = v.d;
    end
    #1;
    chk($sformatf("%s[%0d].co", tag, idx), (sel == 0) ? int'(w_co) : int'(s_co), int'(v.exp_co));
    @(posedge CLK); #1;
    chk($sformatf("%s[%0d].q", tag, idx), (sel == 0) ? int'(w_q) : int'(s_q), int'(v.exp_q));
    chk($sformatf("%s[%0d].ovf", tag, idx), (sel == 0) ? int'(w_ovf) : int'(s_ovf), int'(v.exp_ovf));
  endtask

  task automatic chain_step(input string name, input logic ld, ud, input logic [7:0] d,
                            input logic exp_co, input logic [7:0] exp_q, input logic exp_ovf);
    c_ce = 1'b1; c_ld = ld; c_ud = ud; c_d = d;
    #1;
    chk({name, ".co"}, int'(c_co), int'(exp_co));
    @(posedge CLK); #1;
    chk({name, ".q"}, int'(c_q), int'(exp_q));
    chk({name, ".ovf"}, int'(c_ovf), int'(exp_ovf));
  endtask

  vec_t tw[$];
  vec_t ts[$];

  initial begin
    // Wrap table, starting at Q=0 after a clear.
    //            ce clr ld ud ci d    co q  ovf
    for (int i = 0; i < 12; i++) begin
      tw.push_back(mk(1, 0, 0, 1, 1, 4'd0, (i == 9), 4'((i + 1) % 10), (i == 9)));
    end
    tw.push_back(mk(1, 0, 0, 0, 1, 4'd0,  0, 4'd1, 0));  // 2 -> 1
    tw.push_back(mk(1, 0, 0, 0, 1, 4'd0,  0, 4'd0, 0));  // 1 -> 0
    tw.push_back(mk(1, 0, 0, 0, 1, 4'd0,  1, 4'd9, 1));  // 0 -> 9 wrap
    tw.push_back(mk(1, 0, 0, 0, 1, 4'd0,  0, 4'd8, 0));  // 9 -> 8
    tw.push_back(mk(1, 0, 1, 1, 1, 4'd7,  0, 4'd7, 0));  // load 7
    tw.push_back(mk(1, 0, 1, 1, 1, 4'd13, 0, 4'd9, 0));  // clamp 13
    tw.push_back(mk(0, 0, 1, 1, 1, 4'd3,  0, 4'd9, 0));  // CE=0 blocks load
    tw.push_back(mk(1, 0, 1, 1, 1, 4'd4,  0, 4'd4, 0));  // load beats count at 9
    tw.push_back(mk(1, 0, 0, 1, 0, 4'd0,  0, 4'd4, 0));  // CI=0 holds
    tw.push_back(mk(1, 0, 1, 0, 1, 4'd15, 0, 4'd9, 0));  // clamp 15
    tw.push_back(mk(1, 1, 0, 1, 1, 4'd0,  0, 4'd0, 0));  // CLR beats wrap at 9
    tw.push_back(mk(1, 0, 0, 1, 1, 4'd0,  0, 4'd1, 0));  // 0 -> 1
    tw.push_back(mk(1, 0, 0, 0, 1, 4'd0,  0, 4'd0, 0));  // UD flips: 1 -> 0
    tw.push_back(mk(1, 0, 0, 0, 1, 4'd0,  1, 4'd9, 1));  // 0 -> 9
    tw.push_back(mk(1, 0, 0, 1, 1, 4'd0,  1, 4'd0, 1));  // 9 -> 0, OVF stays high
    tw.push_back(mk(0, 0, 0, 0, 1, 4'd0,  0, 4'd0, 0));  // CE=0 at 0: no carry, hold

    // Saturate table, starting at Q=0.
    ts.push_back(mk(1, 0, 1, 1, 1, 4'd9, 0, 4'd9, 0));   // load 9
    for (int i = 0; i < 3; i++) ts.push_back(mk(1, 0, 0, 1, 1, 4'd0, 1, 4'd9, 1));
    ts.push_back(mk(0, 0, 0, 1, 1, 4'd0, 0, 4'd9, 0));   // idle clears OVF
    ts.push_back(mk(1, 0, 1, 0, 1, 4'd0, 0, 4'd0, 0));   // load 0
    for (int i = 0; i < 2; i++) ts.push_back(mk(1, 0, 0, 0, 1, 4'd0, 1, 4'd0, 1));
    ts.push_back(mk(1, 0, 0, 1, 1, 4'd0, 0, 4'd1, 0));   // leaves the floor

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst.wrap.q", int'(w_q), 0);
    chk("rst.wrap.ovf", int'(w_ovf), 0);
    chk("rst.sat.q", int'(s_q), 0);
    chk("rst.chain.q", int'(c_q), 0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Asynchronous reset mid-count
    run_vec(0, mk(1, 0, 1, 1, 1, 4'd5, 0, 4'd5, 0), 100);
    w_ld = 1'b0; w_ud = 1'b1; w_ci = 1'b1; w_ce = 1'b1;
    #2 RST = 1'b1;
    #1;
    chk("arst.q", int'(w_q), 0);
    chk("arst.ovf", int'(w_ovf), 0);
    @(posedge CLK); #1;
    chk("arst_hold.q", int'(w_q), 0);
    #2 RST = 1'b0;
    @(posedge CLK); #1;
    for (int i = 0; i < 2; i++) run_vec(0, mk(1, 0, 0, 1, 1, 4'd0, 0, 4'(i + 2), 0), 101 + i);
    run_vec(0, mk(0, 1, 0, 1, 1, 4'd0, 0, 4'd0, 0), 103);  // CLR with CE=0

    foreach (tw[i]) run_vec(0, tw[i], i);
    foreach (ts[i]) run_vec(1, ts[i], i);

    // Two-digit BCD chain
    chain_step("ch.ld09", 1, 1, 8'h09, 0, 8'h09, 0);
    chain_step("ch.up10", 0, 1, 8'h00, 0, 8'h10, 0);
    chain_step("ch.ld99", 1, 1, 8'h99, 0, 8'h99, 0);
    chain_step("ch.up00", 0, 1, 8'h00, 1, 8'h00, 1);
    chain_step("ch.dn99", 0, 0, 8'h00, 1, 8'h99, 1);
    chain_step("ch.dn98", 0, 0, 8'h00, 0, 8'h98, 0);
    chain_step("ch.up99", 0, 1, 8'h00, 0, 8'h99, 0);
    chk("ch.lo_ovf", int'(c_ovf_dig[0]), 0);
    c_ce = 1'b0;
    c_clr = 1'b1;
    @(posedge CLK); #1;
    chk("ch.clr.q", int'(c_q), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ud_cnt_mod.md
Name: ud_cnt_mod

Overview:
- Parametrised synchronous up/down counter with a programmable modulus, parallel load, synchronous clear and a wrap or saturate mode.
- Carry-in and carry-out let several instances chain into multi-digit counters, for example BCD digit chains in the calculator display and entry path.
- Replaces fixed 4-bit binary up/down counters wherever a non-power-of-two range or cascading is needed.

Parameters:
- WIDTH, 4: counter width in bits.
- MOD_MAX, 9: highest count value; the range is 0..MOD_MAX. Must satisfy 1 <= MOD_MAX <= 2^WIDTH-1.
- SATURATE, 0: 0 means wrap at the boundaries; 1 means hold at the boundaries.

Ports:
- CLK, in, 1: clock; all state updates on the rising edge.
- RST, in, 1: reset; asynchronous, active-high.
- CE, in, 1: clock enable; gates load and count.
- CLR, in, 1: synchronous clear; independent of CE.
- LD, in, 1: parallel load request; qualified by CE.
- D, in, WIDTH: parallel load value.
- UD, in, 1: direction; 1 means up, 0 means down.
- CI, in, 1: carry-in, the count enable from the previous stage. Tie to 1 when unused.
- Q, out, WIDTH: count value, registered.
- CO, out, 1: carry-out to the next stage's CI. Combinational.
- OVF, out, 1: registered one-cycle pulse on a boundary crossing.

Behaviour:
- Reset: RST high forces Q=0 and OVF=0 immediately. Outputs stay there while RST is high. Reset mid-operation discards any load or count in progress.
- Synchronous priority at each rising CLK edge, highest first:
  1. CLR=1: Q<=0, OVF<=0. Applies even when CE=0.
  2. CE=1 and LD=1: Q<=D if D<=MOD_MAX, otherwise Q<=MOD_MAX (clamp). OVF<=0. CI is ignored.
  3. CE=1, LD=0, CI=1: one count step in the direction given by UD.
  4. Otherwise: Q holds and OVF<=0.
- Count step, up (UD=1):
  - Q<MOD_MAX: Q<=Q+1.
  - Q==MOD_MAX, SATURATE=0: Q<=0 and OVF<=1.
  - Q==MOD_MAX, SATURATE=1: Q holds and OVF<=1.
- Count step, down (UD=0):
  - Q>0: Q<=Q-1.
  - Q==0, SATURATE=0: Q<=MOD_MAX and OVF<=1.
  - Q==0, SATURATE=1: Q holds and OVF<=1.
- OVF is high for exactly the cycle after a boundary event and clears on the next edge unless another boundary event occurs. A continuous saturate attempt keeps OVF high.
- CO = CE & CI & ~LD & ~CLR & ((UD & Q==MOD_MAX) | (~UD & Q==0)).
  - CO is combinational with no registered delay, so a chain of N stages steps together in a single cycle.
  - CO asserts in both modes. Downstream stages must share the same UD, CE and CLR.
- Arithmetic:
  - Compare and increment at WIDTH bits.
  - When MOD_MAX = 2^WIDTH-1, natural overflow must agree with the explicit wrap.
  - Q never leaves 0..MOD_MAX after reset.
- A UD change takes effect on the very next counting edge; no pipelining.
- Latency: load, clear and count all appear on Q one cycle after the qualifying edge.

Decomposition:
- Shared package (calc_pkg):
  - Mode constants CNT_WRAP=0 and CNT_SAT=1.
  - BCD_MAX=9 constant for digit instances.
- The next-state and boundary logic is a single always block; no sub-module.
- A wrapper ud_cnt_chain, parametrised by NDIGITS, is the natural companion. It instantiates NDIGITS copies with CO feeding the next stage's CI, the first CI tied to 1, and a concatenated Q bus.

Test Plan:
1. Reset and clear: run at Q=5, assert RST mid-cycle -> Q=0 and OVF=0 asynchronously. Release, count to 3, then CLR=1 with CE=0 -> Q=0 next edge.
2. BCD wrap up (WIDTH=4, MOD_MAX=9, SATURATE=0), CE=CI=UD=1 for 12 cycles -> Q sequence 1..9,0,1,2; OVF pulses only the cycle after 9->0; CO=1 only while Q=9.
3. Wrap down: from Q=1 with UD=0 for 3 cycles -> Q=0, then 9 with an OVF pulse, then 8; CO=1 only while Q=0.
4. Saturate (SATURATE=1, MOD_MAX=9): hold UD=1 at Q=9 for 3 cycles -> Q stays 9 and OVF=1 all three cycles. Then UD=0 at Q=0 -> Q stays 0 and OVF=1.
5. Load and clamp: CE=1, LD=1, D=7 -> Q=7. D=13 -> Q=9. CE=0, LD=1, D=3 -> Q holds 9. LD=1 with UD=1 and CI=1 -> load wins.
6. Chain: ud_cnt_chain with NDIGITS=2, start at Q=09 and count up -> 10 in one cycle. Reach 99, count up -> 00 with top-digit OVF=1. Count down from 00 -> 99.
